// File: rtl/id_rom_search_if.sv
// Bus bundle for id_rom_search: direct-read port plus search request/result.
// Ports: rd_addr, rd_data, start, key, busy, done, match, match_idx.
interface id_rom_search_if #(
   parameter int ID_WIDTH  = 25,
   parameter int IDX_WIDTH = 3
);
   logic [IDX_WIDTH-1:0] rd_addr;
   logic [ID_WIDTH-1:0]  rd_data;
   logic                 start;
   logic [ID_WIDTH-1:0]  key;
   logic                 busy;
   logic                 done;
   logic                 match;
   logic [IDX_WIDTH-1:0] match_idx;

   modport master (
      output rd_addr, start, key,
      input  rd_data, busy, done, match, match_idx
   );

   modport slave (
      input  rd_addr, start, key,
      output rd_data, busy, done, match, match_idx
   );
endinterface

// File: rtl/id_rom_search.sv
// Fixed identifier ROM with a registered direct-read port and a
// sequential linear search engine (one entry compared per cycle).
// Ports: clk, rst (async active-high), bus (id_rom_search_if.slave):
//   rd_addr -> rd_data (1-cycle), start/key -> busy, done, match, match_idx.
module id_rom_search #(
   parameter int ID_WIDTH  = 25,
   parameter int DEPTH     = 5,
   parameter int IDX_WIDTH = 3
) (
   input logic          clk,
   input logic          rst,
   id_rom_search_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t               state_q;
   logic [ID_WIDTH-1:0]  key_q;
   logic [IDX_WIDTH-1:0] idx_q;
   logic [IDX_WIDTH-1:0] midx_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 match_q;
   logic [ID_WIDTH-1:0]  rd_data_q;
   logic [ID_WIDTH-1:0]  rd_data_d;
   logic [ID_WIDTH-1:0]  scan_ent;
   logic                 hit;
   logic                 last;

   // Out-of-range addresses and unpopulated slots read as the reserved
   // empty value 0. Constants are narrowed/widened to ID_WIDTH.
   function automatic logic [ID_WIDTH-1:0] entry_f(
      input logic [IDX_WIDTH-1:0] a
   );
      logic [ID_WIDTH-1:0] v;
      v = '0;
      if (int'(a) < DEPTH) begin
         case (int'(a))
            0:       v = ID_WIDTH'(25'd25481340);
            1:       v = ID_WIDTH'(25'd25481395);
            2:       v = ID_WIDTH'(25'd25435478);
            3:       v = ID_WIDTH'(25'd25697485);
            4:       v = ID_WIDTH'(25'd25369875);
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   always_comb begin
      rd_data_d = entry_f(bus.rd_addr);
      scan_ent  = entry_f(idx_q);
      // A zero key would otherwise hit every empty slot.
      hit       = (scan_ent == key_q) && (key_q != '0);
      last      = (idx_q == IDX_WIDTH'(DEPTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         midx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  key_q   <= bus.key;
                  match_q <= 1'b0;
                  midx_q  <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (hit) begin
                  match_q <= 1'b1;
                  midx_q  <= idx_q;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (last) begin
                  match_q <= 1'b0;
                  midx_q  <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               idx_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.match     = match_q;
   assign bus.match_idx = midx_q;

endmodule

// File: tb/tb_id_rom_search.sv
// Self-checking bench for id_rom_search: two instances (DEPTH 5 and 8)
// share stimulus and are checked against a behavioural ROM search model.
module tb_id_rom_search;

   localparam int IW = 25;
   localparam int XW = 3;

   logic          clk;
   logic          rst;
   logic          start;
   logic [IW-1:0] key;
   logic [XW-1:0] rd_addr;

   int checks;
   int errors;

   logic [IW-1:0] ent [0:7];

   id_rom_search_if #(.ID_WIDTH(IW), .IDX_WIDTH(XW)) if5 ();
   id_rom_search_if #(.ID_WIDTH(IW), .IDX_WIDTH(XW)) if8 ();

   assign if5.start   = start;
   assign if5.key     = key;
   assign if5.rd_addr = rd_addr;
   assign if8.start   = start;
   assign if8.key     = key;
   assign if8.rd_addr = rd_addr;

   id_rom_search #(.ID_WIDTH(IW), .DEPTH(5), .IDX_WIDTH(XW)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (if5.slave)
   );

   id_rom_search #(.ID_WIDTH(IW), .DEPTH(8), .IDX_WIDTH(XW)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lowest index holding key among the first depth entries; -1 on miss.
   function automatic int find(input logic [IW-1:0] k, input int depth);
      if (k == '0) return -1;
      for (int i = 0; i < depth; i++)
         if (ent[i] == k) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd5"},   if5.rd_data, 0);
      chk({tag, "_busy5"}, if5.busy, 0);
      chk({tag, "_done5"}, if5.done, 0);
      chk({tag, "_m5"},    if5.match, 0);
      chk({tag, "_mi5"},   if5.match_idx, 0);
      chk({tag, "_rd8"},   if8.rd_data, 0);
      chk({tag, "_busy8"}, if8.busy, 0);
      chk({tag, "_done8"}, if8.done, 0);
      chk({tag, "_m8"},    if8.match, 0);
      chk({tag, "_mi8"},   if8.match_idx, 0);
   endtask

   // Per-cycle check of one instance; c counts negedges after the start edge.
   task automatic chk_cyc(
      input string tag, input int c, input int ei, input int depth,
      input logic busy, input logic done,
      input logic match, input logic [XW-1:0] midx
   );
      int lat;
      lat = (ei < 0) ? depth : ei + 1;
      if (busy && done) chk({tag, "_busy_and_done"}, 1, 0);
      if (c == 0) chk({tag, "_match_clr"}, match, 0);
      if (c < lat) begin
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_done_early"}, done, 0);
      end else if (c == lat) begin
         chk({tag, "_done"}, done, 1);
         chk({tag, "_busy_end"}, busy, 0);
         chk({tag, "_match"}, match, (ei >= 0) ? 1 : 0);
         chk({tag, "_midx"}, midx, (ei >= 0) ? ei : 0);
      end else if (c == lat + 1) begin
         chk({tag, "_done_pulse"}, done, 0);
         chk({tag, "_busy_idle"}, busy, 0);
      end
   endtask

   task automatic run_search(
      input string tag, input logic [IW-1:0] k, input int e5, input int e8
   );
      int last;
      last = ((e8 < 0) ? 8 : e8 + 1) + 1;
      @(negedge clk);
      start = 1'b1;
      key   = k;
      @(posedge clk);
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         chk_cyc({tag, "5"}, c, e5, 5, if5.busy, if5.done,
                 if5.match, if5.match_idx);
         chk_cyc({tag, "8"}, c, e8, 8, if8.busy, if8.done,
                 if8.match, if8.match_idx);
         // Second request and key change mid-scan must be ignored.
         if (c == 0) begin
            start = 1'b1;
            key   = IW'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
      chk({tag, "_hold_m5"},  if5.match, (e5 >= 0) ? 1 : 0);
      chk({tag, "_hold_mi5"}, if5.match_idx, (e5 >= 0) ? e5 : 0);
      chk({tag, "_hold_m8"},  if8.match, (e8 >= 0) ? 1 : 0);
      chk({tag, "_hold_mi8"}, if8.match_idx, (e8 >= 0) ? e8 : 0);
   endtask

   task automatic rd_check(input logic [XW-1:0] a, input int e5, input int e8);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      chk("rd5", if5.rd_data, e5);
      chk("rd8", if8.rd_data, e8);
   endtask

   typedef struct {
      string         name;
      logic [IW-1:0] k;
      int            i5;
      int            i8;
   } vec_t;

   vec_t vecs [0:5];

   initial begin
      checks = 0;
      errors = 0;
      ent[0] = 25'd25481340;
      ent[1] = 25'd25481395;
      ent[2] = 25'd25435478;
      ent[3] = 25'd25697485;
      ent[4] = 25'd25369875;
      ent[5] = '0;
      ent[6] = '0;
      ent[7] = '0;

      vecs[0] = '{"hit0",   25'd25481340,  0,  0};
      vecs[1] = '{"hit4",   25'd25369875,  4,  4};
      vecs[2] = '{"miss",   25'd12345678, -1, -1};
      vecs[3] = '{"zero",   25'd0,        -1, -1};
      vecs[4] = '{"hit2",   25'd25435478,  2,  2};
      vecs[5] = '{"hit1",   25'd25481395,  1,  1};

      rst     = 1'b1;
      start   = 1'b0;
      key     = '0;
      rd_addr = '0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      rd_check(3'd3, 25697485, 25697485);
      rd_check(3'd6, 0, 0);

      for (int i = 0; i < 6; i++)
         run_search(vecs[i].name, vecs[i].k, vecs[i].i5, vecs[i].i8);

      for (int i = 0; i < 16; i++) begin
         logic [IW-1:0] k;
         case ($urandom_range(0, 3))
            0:       k = ent[$urandom_range(0, 4)];
            1:       k = '0;
            default: k = IW'($urandom);
         endcase
         run_search("rand", k, find(k, 5), find(k, 8));
      end

      for (int i = 0; i < 16; i++) begin
         logic [XW-1:0] a;
         a = XW'($urandom);
         rd_check(a, (int'(a) < 5) ? int'(ent[a]) : 0, int'(ent[a]));
      end

      // Abort: start at edge n, second start two cycles later, rst at n+2.
      @(negedge clk);
      start = 1'b1;
      key   = 25'd25435478;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy5", if5.busy, 1);
      start = 1'b1;
      key   = 25'd25481340;
      #1 rst = 1'b1;
      #1 chk_zero("abort");
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (if5.done || if8.done || if5.busy || if8.busy)
            chk("abort_quiet", 1, 0);
      end
      chk("abort_m5", if5.match, 0);
      run_search("restart", 25'd25435478, 2, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_rom_search.md
ID_ROM_SEARCH -- requirements
Module: id_rom_search

Interface
REQ-001 Parameter ID_WIDTH, 25, bit width of each stored identifier.
REQ-002 Parameter DEPTH, 5, number of stored entries; legal range 2..256.
REQ-003 Parameter IDX_WIDTH, 3, index width; SHALL satisfy 2**IDX_WIDTH >= DEPTH.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rd_addr  in  IDX_WIDTH  direct-read address.
REQ-007 rd_data  out  ID_WIDTH  registered direct-read data.
REQ-008 start  in  1  search request, sampled on rising edge.
REQ-009 key  in  ID_WIDTH  identifier to search for, captured when start is accepted.
REQ-010 busy  out  1  high while a search is in progress.
REQ-011 done  out  1  single-cycle pulse at search completion.
REQ-012 match  out  1  search result: 1 = key found; held until next accepted start.
REQ-013 match_idx  out  IDX_WIDTH  lowest index whose entry equals key; 0 on miss; held with match.

Function
REQ-014 Contents SHALL be fixed at elaboration: entry0=25481340, entry1=25481395, entry2=25435478, entry3=25697485, entry4=25369875; entries 5..DEPTH-1 = 0; values truncated to ID_WIDTH LSBs if ID_WIDTH < 25.
REQ-015 Value 0 is reserved as "empty"; a key of 0 SHALL never match.
REQ-016 Direct read: rd_data SHALL equal entry[rd_addr] one clock after rd_addr is sampled; rd_addr >= DEPTH yields 0; the read port is independent of and concurrent with the search engine.
REQ-017 FSM states IDLE, SCAN, DONE; one entry compared per cycle in SCAN.
REQ-018 IDLE: start=1 -> latch key, clear match/match_idx, idx=0, go SCAN; busy=1 from that edge.
REQ-019 SCAN: entry[idx]==key and key!=0 -> match=1, match_idx=idx, go DONE; else idx==DEPTH-1 -> match=0, match_idx=0, go DONE; else idx=idx+1.
REQ-020 DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
REQ-021 Latency: start sampled at edge n, hit at index k -> busy high over edges n..n+k+1, done high between edges n+k+1 and n+k+2; miss -> done between edges n+DEPTH and n+DEPTH+1.
REQ-022 start while in SCAN or DONE SHALL be ignored (no queuing); key changes during SCAN SHALL not affect the search in progress.
REQ-023 Duplicate entries: the lowest matching index SHALL be reported (scan stops at first hit).
REQ-024 Index counter SHALL never exceed DEPTH-1; no wrap-around within a search.
REQ-025 busy and done SHALL never be high in the same cycle.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE and rd_data, busy, done, match, match_idx, internal key and idx to 0.
REQ-027 rst asserted during SCAN or DONE SHALL abort the search with no done pulse; first start sampled after rst deasserts begins a fresh search.

Verification
REQ-028 After reset, rd_addr=3 -> rd_data=25697485 next cycle; rd_addr=6 (DEPTH=5) -> rd_data=0.
REQ-029 start with key=25481340 at edge n -> busy high one cycle, done pulse after edge n+1, match=1, match_idx=0.
REQ-030 start with key=25369875 at edge n -> done after edge n+5, match=1, match_idx=4; match/match_idx held through subsequent idle cycles.
REQ-031 start with key=12345678 -> done after edge n+5, match=0, match_idx=0; repeat with DEPTH=8 and key=0 -> done after edge n+8, match=0.
REQ-032 start key=25435478, second start key=25481340 two cycles later, then rst pulse at edge n+2 -> outputs 0 immediately, no done; restart with key=25435478 -> match=1, match_idx=2, second start never honoured.
